lpm_lookup_arbiter: RTL and testbench

//  Shares one lpm_lookup engine among NUM_REQ requesters (per-input header parsers) in the output_port_lookup path.

---
 rtl/lpm_arb_pkg.sv | 16 +
 rtl/lpm_lookup_arbiter_rr_arbiter.sv | 31 +++
 rtl/lpm_lookup_arbiter.sv | 147 ++++++++++++++
 tb/tb_lpm_lookup_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpm_arb_pkg.sv
// Shared definitions for the LPM lookup arbiter: one-hot FSM encodings,
// the miss next-hop value and the statistics counter width.
package lpm_arb_pkg;

  localparam int          STAT_W       = 32;
  localparam logic [31:0] MISS_NEXTHOP = 32'hffff_ffff;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_ISSUE     = 5'b00010,
    ST_WAIT_DONE = 5'b00100,
    ST_RESPOND   = 5'b01000,
    ST_DRAIN     = 5'b10000
  } state_t;

endpackage

// File: rtl/lpm_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester set at or after ptr+1,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [REQ_W-1:0]   grant_idx,
  output logic               any
);

  logic [REQ_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = REQ_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/lpm_lookup_arbiter.sv
// Shares one lpm_lookup engine among NUM_REQ header parsers with round-robin
// grant and one lookup in flight. Optional watchdog: define LPM_ARB_TIMEOUT_EN.
module lpm_lookup_arbiter
  import lpm_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int REQ_W       = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_ip,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_port,
  output logic [31:0]           rsp_nexthop_ip,
  output logic                  lpm_lookup_req,
  output logic [31:0]           lpm_search_ip,
  input  logic                  lpm_lookup_done,
  input  logic [31:0]           lpm_nexthop_ip,
  input  logic [15:0]           lpm_port,
  output logic [STAT_W-1:0]     stat_lookups,
  output logic [STAT_W-1:0]     stat_misses,
  input  logic                  stat_clear
);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t               state;
  logic [REQ_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   gsel;
  logic [NUM_REQ-1:0]   grant;
  logic [REQ_W-1:0]     grant_idx;
  logic                 any;
  logic                 accept;
  logic                 miss;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign accept = (state == ST_IDLE) && any;
  assign miss   = (state == ST_RESPOND) && (rsp_port == 16'h0000);

`ifdef LPM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timed_out;
`else
  wire unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      ptr            <= REQ_W'(NUM_REQ - 1);
      gsel           <= '0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_port       <= '0;
      rsp_nexthop_ip <= MISS_NEXTHOP;
      lpm_lookup_req <= 1'b0;
      lpm_search_ip  <= '0;
      stat_lookups   <= '0;
      stat_misses    <= '0;
`ifdef LPM_ARB_TIMEOUT_EN
      wd_cnt         <= '0;
      timed_out      <= 1'b0;
`endif
    end else begin
      req_ready      <= '0;
      rsp_valid      <= '0;
      lpm_lookup_req <= 1'b0;

      // Clear has priority over a coincident increment.
      if (stat_clear)  stat_lookups <= '0;
      else if (accept) stat_lookups <= sat_inc(stat_lookups);
      if (stat_clear)  stat_misses  <= '0;
      else if (miss)   stat_misses  <= sat_inc(stat_misses);

      case (state)
        ST_IDLE: begin
          if (any) begin
            req_ready     <= grant;
            gsel          <= grant;
            ptr           <= grant_idx;
            lpm_search_ip <= req_ip[32*grant_idx +: 32];
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          lpm_lookup_req <= 1'b1;
          state          <= ST_WAIT_DONE;
`ifdef LPM_ARB_TIMEOUT_EN
          wd_cnt         <= '0;
          timed_out      <= 1'b0;
`endif
        end
        ST_WAIT_DONE: begin
          if (lpm_lookup_done) begin
            rsp_port       <= lpm_port;
            rsp_nexthop_ip <= lpm_nexthop_ip;
            rsp_valid      <= gsel;
            state          <= ST_RESPOND;
          end
`ifdef LPM_ARB_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            rsp_port       <= '0;
            rsp_nexthop_ip <= MISS_NEXTHOP;
            rsp_valid      <= gsel;
            timed_out      <= 1'b1;
            state          <= ST_RESPOND;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        ST_RESPOND: begin
`ifdef LPM_ARB_TIMEOUT_EN
          // A late done landing right here already ends the drain.
          if (timed_out && !lpm_lookup_done) state <= ST_DRAIN;
          else                               state <= ST_IDLE;
`else
          state <= ST_IDLE;
`endif
        end
`ifdef LPM_ARB_TIMEOUT_EN
        ST_DRAIN: begin
          if (lpm_lookup_done) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpm_lookup_arbiter.sv
// Directed bench for lpm_lookup_arbiter with a simple engine model that answers
// eng_n cycles after lpm_lookup_req (eng_n == 0 means never).
module tb_lpm_lookup_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_ip;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [15:0]  rsp_port;
  logic [31:0]  rsp_nexthop_ip;
  logic         lpm_lookup_req;
  logic [31:0]  lpm_search_ip;
  logic         lpm_lookup_done;
  logic [31:0]  lpm_nexthop_ip;
  logic [15:0]  lpm_port;
  logic [31:0]  stat_lookups;
  logic [31:0]  stat_misses;
  logic         stat_clear;

  logic         eng_done;
  logic         stray_done;
  int           eng_n;
  int           eng_cnt;
  logic [15:0]  eng_port;
  logic [31:0]  eng_nh;

  int checks;
  int errors;

  assign lpm_lookup_done = eng_done | stray_done;
  assign lpm_port        = eng_port;
  assign lpm_nexthop_ip  = eng_nh;

  lpm_lookup_arbiter #(
    .NUM_REQ     (4),
    .REQ_W       (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ip          (req_ip),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_port        (rsp_port),
    .rsp_nexthop_ip  (rsp_nexthop_ip),
    .lpm_lookup_req  (lpm_lookup_req),
    .lpm_search_ip   (lpm_search_ip),
    .lpm_lookup_done (lpm_lookup_done),
    .lpm_nexthop_ip  (lpm_nexthop_ip),
    .lpm_port        (lpm_port),
    .stat_lookups    (stat_lookups),
    .stat_misses     (stat_misses),
    .stat_clear      (stat_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine model, evaluated mid-cycle so done is stable across the next edge.
  initial begin
    eng_done = 1'b0;
    eng_cnt  = 0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (reset) begin
        eng_cnt = 0;
      end else begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) eng_done = 1'b1;
        end
        if (lpm_lookup_req && eng_n > 0) eng_cnt = eng_n;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (req_ready != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (rsp_valid != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = '0;
    req_ip     = '0;
    stray_done = 1'b0;
    stat_clear = 1'b0;
    eng_n      = 3;
    eng_port   = '0;
    eng_nh     = '0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_port, lpm_lookup_req, lpm_search_ip,
         stat_lookups, stat_misses} !== '0) begin
      errors++;
      $display("FAIL reset_zero_outputs ready=%b rsp=%b port=%h req=%b ip=%h lk=%0d ms=%0d expected all 0",
               req_ready, rsp_valid, rsp_port, lpm_lookup_req, lpm_search_ip, stat_lookups, stat_misses);
    end
    checks++;
    if (rsp_nexthop_ip !== 32'hffffffff) begin
      errors++;
      $display("FAIL reset_nexthop got %h expected ffffffff", rsp_nexthop_ip);
    end
  endtask

  task automatic test_single();
    bit seen;
    req_ip[31:0] = 32'h0a000001;
    eng_port     = 16'h0004;
    eng_nh       = 32'h0a000001;
    eng_n        = 3;
    req_valid    = 4'b0001;
    tick();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got %b expected 0001", req_ready);
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (lpm_lookup_req !== 1'b1 || lpm_search_ip !== 32'h0a000001) begin
      errors++;
      $display("FAIL single_issue req=%b ip=%h expected 1/0a000001", lpm_lookup_req, lpm_search_ip);
    end
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (rsp_valid != 4'b0000) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL single_early_rsp got rsp before T+5 expected none");
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_port !== 16'h0004 || rsp_nexthop_ip !== 32'h0a000001) begin
      errors++;
      $display("FAIL single_rsp got %b/%h/%h expected 0001/0004/0a000001", rsp_valid, rsp_port, rsp_nexthop_ip);
    end
    checks++;
    if (stat_lookups !== 32'd1) begin
      errors++;
      $display("FAIL single_stat_lookups got %0d expected 1", stat_lookups);
    end
    tick();
  endtask

  task automatic test_round_robin();
    bit         ok;
    int         exp;
    logic [3:0] exp_oh;
    logic [31:0] exp_ip;
    apply_reset();
    req_ip    = {32'h0a000304, 32'h0a000203, 32'h0a000102, 32'h0a000001};
    eng_port  = 16'h0010;
    eng_nh    = 32'h01020304;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp    = k % 4;
      exp_oh = 4'b0001 << exp;
      exp_ip = req_ip[32*exp +: 32];
      wait_ready(20, ok);
      checks++;
      if (!ok || req_ready !== exp_oh) begin
        errors++;
        $display("FAIL rr_grant_%0d got %b expected %b", k, req_ready, exp_oh);
      end
      tick();
      checks++;
      if (lpm_search_ip !== exp_ip) begin
        errors++;
        $display("FAIL rr_search_ip_%0d got %h expected %h", k, lpm_search_ip, exp_ip);
      end
      wait_rsp(20, ok);
      checks++;
      if (!ok || rsp_valid !== exp_oh || rsp_port !== 16'h0010) begin
        errors++;
        $display("FAIL rr_rsp_%0d got %b/%h expected %b/0010", k, rsp_valid, rsp_port, exp_oh);
      end
    end
    req_valid = 4'b0000;
    checks++;
    if (stat_lookups !== 32'd8) begin
      errors++;
      $display("FAIL rr_stat_lookups got %0d expected 8", stat_lookups);
    end
    tick();
  endtask

  task automatic test_miss();
    bit ok;
    eng_port  = 16'h0000;
    eng_nh    = 32'hffffffff;
    req_valid = 4'b0010;
    wait_ready(20, ok);
    checks++;
    if (!ok || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL miss_ready got %b expected 0010", req_ready);
    end
    req_valid = 4'b0000;
    wait_rsp(20, ok);
    checks++;
    if (!ok || rsp_valid !== 4'b0010 || rsp_port !== 16'h0000 || rsp_nexthop_ip !== 32'hffffffff) begin
      errors++;
      $display("FAIL miss_rsp got %b/%h/%h expected 0010/0000/ffffffff", rsp_valid, rsp_port, rsp_nexthop_ip);
    end
    tick();
    checks++;
    if (stat_misses !== 32'd1 || stat_lookups !== 32'd9) begin
      errors++;
      $display("FAIL miss_stats got misses=%0d lookups=%0d expected 1/9", stat_misses, stat_lookups);
    end
  endtask

  task automatic test_stat_clear();
    bit ok;
    eng_port   = 16'h0002;
    eng_nh     = 32'h0b000001;
    stat_clear = 1'b1;
    req_valid  = 4'b0001;
    tick();
    stat_clear = 1'b0;
    checks++;
    if (req_ready !== 4'b0001 || stat_lookups !== 32'd0 || stat_misses !== 32'd0) begin
      errors++;
      $display("FAIL clear_wins got ready=%b lk=%0d ms=%0d expected 0001/0/0", req_ready, stat_lookups, stat_misses);
    end
    req_valid = 4'b0000;
    wait_rsp(20, ok);
    checks++;
    if (!ok || rsp_port !== 16'h0002 || rsp_nexthop_ip !== 32'h0b000001) begin
      errors++;
      $display("FAIL clear_rsp got %h/%h expected 0002/0b000001", rsp_port, rsp_nexthop_ip);
    end
    tick();
    checks++;
    if (stat_lookups !== 32'd0 || stat_misses !== 32'd0) begin
      errors++;
      $display("FAIL clear_after got lk=%0d ms=%0d expected 0/0", stat_lookups, stat_misses);
    end
  endtask

  task automatic test_stray_done();
    bit seen;
    bit ok;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (rsp_valid != 4'b0000 || req_ready != 4'b0000 || lpm_lookup_req) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL stray_activity got activity after stray done expected none");
    end
    req_valid = 4'b0100;
    tick();
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL stray_still_idle got ready=%b expected 0100", req_ready);
    end
    req_valid = 4'b0000;
    wait_rsp(20, ok);
    checks++;
    if (!ok || rsp_valid !== 4'b0100) begin
      errors++;
      $display("FAIL stray_followup_rsp got %b expected 0100", rsp_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_lookup();
    bit ok;
    bit seen;
    eng_n     = 10;
    eng_port  = 16'h0008;
    eng_nh    = 32'h0c000001;
    req_valid = 4'b1000;
    wait_ready(20, ok);
    checks++;
    if (!ok || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_ready got %b expected 1000", req_ready);
    end
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_port, lpm_lookup_req, lpm_search_ip,
         stat_lookups, stat_misses} !== '0 || rsp_nexthop_ip !== 32'hffffffff) begin
      errors++;
      $display("FAIL rstmid_outputs ready=%b rsp=%b port=%h req=%b ip=%h nh=%h lk=%0d ms=%0d expected reset values",
               req_ready, rsp_valid, rsp_port, lpm_lookup_req, lpm_search_ip, rsp_nexthop_ip, stat_lookups, stat_misses);
    end
    reset = 1'b0;
    eng_n = 3;
    seen  = 1'b0;
    repeat (8) begin
      tick();
      if (rsp_valid != 4'b0000) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_rsp got response after reset expected none");
    end
    req_valid = 4'b1111;
    wait_ready(20, ok);
    checks++;
    if (!ok || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_first_grant got %b expected 0001", req_ready);
    end
    req_valid = 4'b0000;
    wait_rsp(20, ok);
    checks++;
    if (!ok || rsp_valid !== 4'b0001 || rsp_port !== 16'h0008 || stat_lookups !== 32'd1) begin
      errors++;
      $display("FAIL rstmid_rsp got %b/%h lk=%0d expected 0001/0008 lk=1", rsp_valid, rsp_port, stat_lookups);
    end
    tick();
  endtask

`ifdef LPM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    bit seen;
    eng_n     = 0;
    req_valid = 4'b0010;
    wait_ready(20, ok);
    checks++;
    if (!ok || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL to_ready got %b expected 0010", req_ready);
    end
    req_valid = 4'b0000;
    wait_rsp(40, ok);
    checks++;
    if (!ok || rsp_valid !== 4'b0010 || rsp_port !== 16'h0000 || rsp_nexthop_ip !== 32'hffffffff) begin
      errors++;
      $display("FAIL to_rsp got %b/%h/%h expected 0010/0000/ffffffff", rsp_valid, rsp_port, rsp_nexthop_ip);
    end
    req_valid = 4'b1111;
    tick();
    checks++;
    if (stat_misses !== 32'd1) begin
      errors++;
      $display("FAIL to_miss_count got %0d expected 1", stat_misses);
    end
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (req_ready != 4'b0000) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL to_drain_accept got an accept during drain expected none");
    end
    eng_n      = 3;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL to_late_done_rsp got %b expected 0000", rsp_valid);
    end
    tick();
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL to_after_drain_grant got %b expected 0100", req_ready);
    end
    req_valid = 4'b0000;
    wait_rsp(20, ok);
    checks++;
    if (!ok || rsp_valid !== 4'b0100 || rsp_port !== 16'h0008) begin
      errors++;
      $display("FAIL to_after_drain_rsp got %b/%h expected 0100/0008", rsp_valid, rsp_port);
    end
    tick();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_miss();
    test_stat_clear();
    test_stray_done();
    test_reset_mid_lookup();
`ifdef LPM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
